// File: rtl/seq_detect_dual_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_dual_prog
//
// Programmable dual-pattern serial bit-sequence detector. Two patterns (A, B)
// of runtime length 1..MAX_LEN are compared against a shift history of the
// qualified input stream. Each pattern has a one-cycle hit pulse and a
// saturating hit counter. Overlapping and non-overlapping modes are
// supported. Reset defaults give the classic 101 / 010 overlapping detector.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   din_valid    in   qualifies din; the stream only advances when high
//   din          in   serial data bit
//   cfg_load     in   one-cycle strobe; latches all cfg_* inputs
//   cfg_pat_a    in   pattern A, bit cfg_len-1 is received first, bit 0 last
//   cfg_pat_b    in   pattern B, same ordering as A
//   cfg_len      in   pattern length (0 or > MAX_LEN parks the block in IDLE)
//   cfg_overlap  in   1 = overlapping matches, 0 = non-overlapping
//   cnt_clr      in   synchronous clear of both hit counters
//   armed        out  high while a valid configuration is loaded
//   det_a        out  one-cycle pulse on a pattern A hit
//   det_b        out  one-cycle pulse on a pattern B hit
//   detected     out  det_a | det_b, registered
//   cnt_a        out  saturating count of A hits
//   cnt_b        out  saturating count of B hits
// -----------------------------------------------------------------------------
module seq_detect_dual_prog #(
  parameter int                 MAX_LEN   = 8,
  parameter int                 CNT_W     = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT_A = MAX_LEN'(8'b0000_0101),
  parameter logic [MAX_LEN-1:0] DEF_PAT_B = MAX_LEN'(8'b0000_0010),
  parameter int                 DEF_LEN   = 3,
  parameter bit                 DEF_OVL   = 1'b1,
  localparam int                LW        = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat_a,
  input  logic [MAX_LEN-1:0] cfg_pat_b,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               armed,
  output logic               det_a,
  output logic               det_b,
  output logic               detected,
  output logic [CNT_W-1:0]   cnt_a,
  output logic [CNT_W-1:0]   cnt_b
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SEARCH = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic               r_det_a;
  logic               r_det_b;
  logic               r_detected;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;

  // Active configuration, changed only by cfg_load.
  logic [MAX_LEN-1:0] r_pat_a;
  logic [MAX_LEN-1:0] r_pat_b;
  logic [LW-1:0]      r_len;
  logic               r_ovl;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LW-1:0]      w_fill_nxt;
  logic               w_det_a_nxt;
  logic               w_det_b_nxt;

  logic               w_cfg_ok;
  logic [MAX_LEN:0]   w_mask_wide;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_hist_shift;
  logic [LW-1:0]      w_fill_inc;
  logic               w_full;
  logic               w_match_a;
  logic               w_match_b;

  assign w_cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

  // Mask of the low r_len bits. One extra bit of width keeps
  // r_len == MAX_LEN from overflowing the shift.
  assign w_mask_wide = ((MAX_LEN+1)'(1) << r_len) - (MAX_LEN+1)'(1);
  assign w_mask      = w_mask_wide[MAX_LEN-1:0];

  // History and fill as they would be after accepting the current bit.
  // Fill saturates at MAX_LEN so it never wraps during long SEARCH runs.
  assign w_hist_shift = {r_hist[MAX_LEN-2:0], din};
  assign w_fill_inc   = (r_fill >= LW'(MAX_LEN)) ? r_fill : r_fill + LW'(1);
  assign w_full       = (w_fill_inc >= r_len);

  assign w_match_a = (((w_hist_shift ^ r_pat_a) & w_mask) == '0);
  assign w_match_b = (((w_hist_shift ^ r_pat_b) & w_mask) == '0);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_det_a_nxt = 1'b0;
    w_det_b_nxt = 1'b0;

    if (cfg_load) begin
      // A load wins over a same-cycle data bit; that bit is dropped.
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_state_nxt = w_cfg_ok ? ST_FILL : ST_IDLE;
    end else if (din_valid && (r_state != ST_IDLE)) begin
      w_hist_nxt = w_hist_shift;
      w_fill_nxt = w_fill_inc;

      if (w_full) begin
        w_det_a_nxt = w_match_a;
        w_det_b_nxt = w_match_b;
      end

      if ((w_det_a_nxt || w_det_b_nxt) && !r_ovl) begin
        // Non-overlapping: the next hit must be built from fresh bits only.
        w_fill_nxt  = '0;
        w_state_nxt = ST_FILL;
      end else begin
        w_state_nxt = w_full ? ST_SEARCH : ST_FILL;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, history and detection flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_FILL;
      r_hist     <= '0;
      r_fill     <= '0;
      r_det_a    <= 1'b0;
      r_det_b    <= 1'b0;
      r_detected <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hist     <= w_hist_nxt;
      r_fill     <= w_fill_nxt;
      r_det_a    <= w_det_a_nxt;
      r_det_b    <= w_det_b_nxt;
      r_detected <= w_det_a_nxt | w_det_b_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  // An invalid length is still stored; IDLE never looks at it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat_a <= DEF_PAT_A;
      r_pat_b <= DEF_PAT_B;
      r_len   <= LW'(DEF_LEN);
      r_ovl   <= DEF_OVL;
    end else if (cfg_load) begin
      r_pat_a <= cfg_pat_a;
      r_pat_b <= cfg_pat_b;
      r_len   <= cfg_len;
      r_ovl   <= cfg_overlap;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating hit counters
  // ---------------------------------------------------------------------------
  // Counters advance on the same edge that raises the matching det flag, so a
  // pulse and its updated count are visible together. cnt_clr wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (cnt_clr) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_det_a_nxt && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + CNT_W'(1);
      if (w_det_b_nxt && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign armed    = (r_state != ST_IDLE);
  assign det_a    = r_det_a;
  assign det_b    = r_det_b;
  assign detected = r_detected;
  assign cnt_a    = r_cnt_a;
  assign cnt_b    = r_cnt_b;

endmodule

// File: tb/tb_seq_detect_dual_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_dual_prog
//
// Two instances share all stimulus: dut0 with default CNT_W = 8 and dut1 with
// CNT_W = 2 to exercise counter saturation. Directed bit vectors carry
// hand-computed hit masks; every expected hit is pushed into a per-instance
// queue together with its cycle number and the expected counter values. A
// monitor per instance pops an entry whenever that instance pulses.
// -----------------------------------------------------------------------------
module tb_seq_detect_dual_prog;

  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);

  typedef struct {
    int cyc;
    bit a;
    bit b;
    int ca;
    int cb;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pat_a = '0;
  logic [MAX_LEN-1:0] cfg_pat_b = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;

  logic       armed0, det_a0, det_b0, detected0;
  logic [7:0] cnt_a0, cnt_b0;
  logic       armed1, det_a1, det_b1, detected1;
  logic [1:0] cnt_a1, cnt_b1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   m_ca[2];
  int   m_cb[2];
  int   m_max[2] = '{255, 3};

  seq_detect_dual_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pat_a(cfg_pat_a), .cfg_pat_b(cfg_pat_b),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .armed(armed0), .det_a(det_a0), .det_b(det_b0), .detected(detected0),
    .cnt_a(cnt_a0), .cnt_b(cnt_b0)
  );

  seq_detect_dual_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pat_a(cfg_pat_a), .cfg_pat_b(cfg_pat_b),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .armed(armed1), .det_a(det_a1), .det_b(det_b1), .detected(detected1),
    .cnt_a(cnt_a1), .cnt_b(cnt_b1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: one per instance, fire on any pulse
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset && (det_a0 || det_b0 || detected0)) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut0 unexpected pulse: det_a=%b det_b=%b at cycle %0d, none expected",
                 det_a0, det_b0, cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0 hit cycle", cyc, e.cyc);
        check("dut0 det_a", {31'd0, det_a0}, {31'd0, e.a});
        check("dut0 det_b", {31'd0, det_b0}, {31'd0, e.b});
        check("dut0 detected", {31'd0, detected0}, {31'd0, e.a | e.b});
        check("dut0 cnt_a", {24'd0, cnt_a0}, e.ca);
        check("dut0 cnt_b", {24'd0, cnt_b0}, e.cb);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (det_a1 || det_b1 || detected1)) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut1 unexpected pulse: det_a=%b det_b=%b at cycle %0d, none expected",
                 det_a1, det_b1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1 hit cycle", cyc, e.cyc);
        check("dut1 det_a", {31'd0, det_a1}, {31'd0, e.a});
        check("dut1 det_b", {31'd0, det_b1}, {31'd0, e.b});
        check("dut1 detected", {31'd0, detected1}, {31'd0, e.a | e.b});
        check("dut1 cnt_a", {30'd0, cnt_a1}, e.ca);
        check("dut1 cnt_b", {30'd0, cnt_b1}, e.cb);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Update the counter model for the edge just taken and queue expected hits.
  task automatic push_hit(input bit ea, input bit eb, input bit clr);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_ca[k] = 0;
        m_cb[k] = 0;
      end else begin
        if (ea && m_ca[k] < m_max[k]) m_ca[k]++;
        if (eb && m_cb[k] < m_max[k]) m_cb[k]++;
      end
    end
    if (ea || eb) begin
      e.cyc = cyc; e.a = ea; e.b = eb;
      e.ca = m_ca[0]; e.cb = m_cb[0];
      q0.push_back(e);
      e.ca = m_ca[1]; e.cb = m_cb[1];
      q1.push_back(e);
    end
  endtask

  task automatic send(input bit b, input bit ea, input bit eb, input bit clr);
    din_valid = 1'b1;
    din       = b;
    cnt_clr   = clr;
    @(posedge clk); #1;
    din_valid = 1'b0;
    cnt_clr   = 1'b0;
    push_hit(ea, eb, clr);
  endtask

  // bits[n-1] is sent first; ea/eb masks mark the bits that complete a hit.
  task automatic send_vec(input logic [31:0] bits, input logic [31:0] ea,
                          input logic [31:0] eb, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], ea[i], eb[i], 1'b0);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cycle();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    push_hit(1'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pa, input logic [MAX_LEN-1:0] pb,
                      input logic [LW-1:0] len, input bit ovl,
                      input bit dv, input bit d);
    cfg_pat_a   = pa;
    cfg_pat_b   = pb;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    din_valid   = dv;
    din         = d;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_ca[k] = 0;
      m_cb[k] = 0;
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, " dut0 cnt_a"}, {24'd0, cnt_a0}, m_ca[0]);
    check({tag, " dut0 cnt_b"}, {24'd0, cnt_b0}, m_cb[0]);
    check({tag, " dut1 cnt_a"}, {30'd0, cnt_a1}, m_ca[1]);
    check({tag, " dut1 cnt_b"}, {30'd0, cnt_b1}, m_cb[1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " armed0"}, {31'd0, armed0}, 1);
    check({tag, " armed1"}, {31'd0, armed1}, 1);
    check({tag, " det_a0"}, {31'd0, det_a0}, 0);
    check({tag, " det_b0"}, {31'd0, det_b0}, 0);
    check({tag, " detected0"}, {31'd0, detected0}, 0);
    check({tag, " cnt_a0"}, {24'd0, cnt_a0}, 0);
    check({tag, " cnt_b0"}, {24'd0, cnt_b0}, 0);
    check({tag, " cnt_a1"}, {30'd0, cnt_a1}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ca[k] = 0;
      m_cb[k] = 0;
    end

    // Reset state
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: defaults 101/010 overlapping, stream 1010011
    send_vec(32'b1010011, 32'b0010000, 32'b0001000, 7);
    idle(2);
    check("t1 dut0 cnt_a", {24'd0, cnt_a0}, 1);
    check("t1 dut0 cnt_b", {24'd0, cnt_b0}, 1);

    // 2: A=1010, B=1111, len 4, overlap then non-overlap
    clr_cycle();
    load(8'b1010, 8'b1111, 4'd4, 1'b1, 1'b0, 1'b0);
    send_vec(32'b10101010, 32'b00010101, 32'b0, 8);
    idle(2);
    check("t2 ovl dut0 cnt_a", {24'd0, cnt_a0}, 3);
    check_cnts("t2 ovl");
    clr_cycle();
    load(8'b1010, 8'b1111, 4'd4, 1'b0, 1'b0, 1'b0);
    send_vec(32'b10101010, 32'b00010001, 32'b0, 8);
    idle(2);
    check("t2 novl dut0 cnt_a", {24'd0, cnt_a0}, 2);
    check_cnts("t2 novl");

    // 3: gaps between valid bits, then reset in the middle of a match
    do_reset();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    check_cnts("t3 gaps");
    send(1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_ca[k] = 0;
      m_cb[k] = 0;
    end
    #1 check_reset_outputs("t3 midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    send(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // 4: invalid lengths park the detector; valid load re-arms it
    load(8'b101, 8'b010, 4'd0, 1'b1, 1'b0, 1'b0);
    check("t4 len0 armed0", {31'd0, armed0}, 0);
    check("t4 len0 armed1", {31'd0, armed1}, 0);
    send_vec(32'b10101010, 32'b0, 32'b0, 8);
    load(8'b101, 8'b010, 4'(MAX_LEN + 1), 1'b1, 1'b0, 1'b0);
    check("t4 len9 armed0", {31'd0, armed0}, 0);
    send_vec(32'b01010101, 32'b0, 32'b0, 8);
    load(8'b101, 8'b010, 4'd3, 1'b1, 1'b0, 1'b0);
    check("t4 valid armed0", {31'd0, armed0}, 1);
    check("t4 valid armed1", {31'd0, armed1}, 1);
    send_vec(32'b101, 32'b001, 32'b0, 3);
    idle(2);

    // 5: saturation on the 2-bit counters, then clear racing a hit
    do_reset();
    send_vec(32'b10101010101, 32'b00101010101, 32'b00010101010, 11);
    idle(1);
    check("t5 dut1 cnt_a sat", {30'd0, cnt_a1}, 3);
    check("t5 dut1 cnt_b sat", {30'd0, cnt_b1}, 3);
    check("t5 dut0 cnt_a", {24'd0, cnt_a0}, 5);
    check("t5 dut0 cnt_b", {24'd0, cnt_b0}, 4);
    send(1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("t5 clr dut0 cnt_a", {24'd0, cnt_a0}, 0);
    check("t5 clr dut1 cnt_a", {30'd0, cnt_a1}, 0);

    // 6: load drops the same-cycle bit and breaks a straddling match
    do_reset();
    send_vec(32'b10, 32'b0, 32'b0, 2);
    load(8'b101, 8'b010, 4'd3, 1'b1, 1'b1, 1'b1);
    send_vec(32'b101, 32'b001, 32'b0, 3);
    idle(3);
    check_cnts("t6");

    // Every queued hit must have been seen
    check("dut0 pending hits", q0.size(), 0);
    check("dut1 pending hits", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
